// File: rtl/bcd_share_sched.sv
// Round-robin sharing of one binary-to-BCD converter among three display requesters.
// Latches request pulses, drives the granted value, waits out the converter latency, captures the result.
module bcd_share_sched #(
  parameter int BIN_W    = 13,
  parameter int BCD_W    = 16,
  parameter int CONV_LAT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [BIN_W-1:0] bin0,
  input  logic [BIN_W-1:0] bin1,
  input  logic [BIN_W-1:0] bin2,
  output logic [BCD_W-1:0] bcd0,
  output logic [BCD_W-1:0] bcd1,
  output logic [BCD_W-1:0] bcd2,
  output logic [2:0]       ack,
  output logic [BIN_W-1:0] conv_bin,
  input  logic [BCD_W-1:0] conv_bcd,
  output logic             busy,
  output logic [1:0]       grant_id
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int              CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pending_q, pending_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic [BIN_W-1:0] conv_bin_q, conv_bin_d;
  logic [BCD_W-1:0] bcd0_q, bcd0_d, bcd1_q, bcd1_d, bcd2_q, bcd2_d;
  logic [2:0]       ack_q, ack_d;
  logic [2:0]       pick_s;
  logic [BIN_W-1:0] pick_bin_s;

  // Returns {valid, index} of the first pending requester starting at ptr, modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [1:0] ptr);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      int unsigned i;
      i = (int'(ptr) + k) % 3;
      if (pend[i]) begin
        r = {1'b1, 2'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Round-robin arbitration and selection of the granted binary value.
  always_comb begin
    pick_s = rr_pick(pending_q, rr_ptr_q);
    case (pick_s[1:0])
      2'd0:    pick_bin_s = bin0;
      2'd1:    pick_bin_s = bin1;
      default: pick_bin_s = bin2;
    endcase
  end

  // Next-state logic: grant from IDLE, count and capture in WAIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q | req;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    conv_bin_d = conv_bin_q;
    bcd0_d     = bcd0_q;
    bcd1_d     = bcd1_q;
    bcd2_d     = bcd2_q;
    ack_d      = 3'b000;
    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          state_d    = WAIT;
          grant_d    = pick_s[1:0];
          cnt_d      = {CNT_W{1'b0}};
          conv_bin_d = pick_bin_s;
          // A request on the granting edge re-arms the bit so it is served again.
          pending_d  = (pending_q & ~(3'b001 << pick_s[1:0])) | req;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          ack_d    = 3'b001 << grant_q;
          rr_ptr_d = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          grant_d  = 2'd0;
          case (grant_q)
            2'd0:    bcd0_d = conv_bcd;
            2'd1:    bcd1_d = conv_bcd;
            default: bcd2_d = conv_bcd;
          endcase
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      pending_q  <= 3'b000;
      rr_ptr_q   <= 2'd0;
      grant_q    <= 2'd0;
      conv_bin_q <= {BIN_W{1'b0}};
      bcd0_q     <= {BCD_W{1'b0}};
      bcd1_q     <= {BCD_W{1'b0}};
      bcd2_q     <= {BCD_W{1'b0}};
      ack_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      conv_bin_q <= conv_bin_d;
      bcd0_q     <= bcd0_d;
      bcd1_q     <= bcd1_d;
      bcd2_q     <= bcd2_d;
      ack_q      <= ack_d;
    end
  end

  assign bcd0     = bcd0_q;
  assign bcd1     = bcd1_q;
  assign bcd2     = bcd2_q;
  assign ack      = ack_q;
  assign conv_bin = conv_bin_q;
  assign busy     = (state_q == WAIT);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_bcd_share_sched.sv
// Directed bench for bcd_share_sched with a behavioural 14-stage converter model.
module tb_bcd_share_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [12:0] bin0, bin1, bin2;
  logic [15:0] bcd0, bcd1, bcd2;
  logic [2:0]  ack;
  logic [12:0] conv_bin;
  logic [15:0] conv_bcd;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int failures = 0;

  bcd_share_sched #(.BIN_W(13), .BCD_W(16), .CONV_LAT(16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .bin0(bin0), .bin1(bin1), .bin2(bin2),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
    .ack(ack), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Converter model: result of the value loaded 14 edges earlier, cleared by reset.
  logic [12:0] pipe [14];
  function automatic logic [15:0] to_bcd(input logic [12:0] v);
    int n;
    n = int'(v);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 14; k++) pipe[k] <= 13'd0;
    end else begin
      pipe[0] <= conv_bin;
      for (int k = 1; k < 14; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign conv_bcd = to_bcd(pipe[13]);

  typedef struct {
    logic [1:0]  id;
    logic [12:0] bin;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] model_bcd [3];
  logic [2:0]  ack_log [$];
  int          nack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] m);
    req = m;
    tick();
    req = 3'b000;
  endtask

  task automatic wait_ack(input string nm, input int exp_cyc, input logic [2:0] exp_ack);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 3'b000 && n < 200);
    chk({nm, "_lat"}, 32'(n), 32'(exp_cyc));
    chk({nm, "_ack"}, 32'(ack), 32'(exp_ack));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) model_bcd[k] = 16'h0000;
  endtask

  initial begin
    req = 3'b000; bin0 = 13'd0; bin1 = 13'd0; bin2 = 13'd0;
    vecs[0] = '{id: 2'd1, bin: 13'd1234, exp_bcd: 16'h1234};
    vecs[1] = '{id: 2'd0, bin: 13'd42,   exp_bcd: 16'h0042};
    vecs[2] = '{id: 2'd2, bin: 13'd4096, exp_bcd: 16'h4096};
    vecs[3] = '{id: 2'd1, bin: 13'd5,    exp_bcd: 16'h0005};
    vecs[4] = '{id: 2'd0, bin: 13'd8190, exp_bcd: 16'h8190};

    do_reset();
    chk("rst_bcd0", 32'(bcd0), 32'h0);
    chk("rst_bcd1", 32'(bcd1), 32'h0);
    chk("rst_bcd2", 32'(bcd2), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_conv_bin", 32'(conv_bin), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);

    // Single requests from the table.
    for (int v = 0; v < 5; v++) begin
      bin0 = 13'd1; bin1 = 13'd2; bin2 = 13'd3;
      case (vecs[v].id)
        2'd0:    bin0 = vecs[v].bin;
        2'd1:    bin1 = vecs[v].bin;
        default: bin2 = vecs[v].bin;
      endcase
      pulse(3'b001 << vecs[v].id);
      tick();
      chk("vec_busy", 32'(busy), 32'h1);
      chk("vec_conv_bin", 32'(conv_bin), 32'(vecs[v].bin));
      chk("vec_grant", 32'(grant_id), 32'(vecs[v].id));
      bin0 = 13'd100; bin1 = 13'd200; bin2 = 13'd300;
      wait_ack("vec", 16, 3'b001 << vecs[v].id);
      model_bcd[vecs[v].id] = vecs[v].exp_bcd;
      chk("vec_bcd0", 32'(bcd0), 32'(model_bcd[0]));
      chk("vec_bcd1", 32'(bcd1), 32'(model_bcd[1]));
      chk("vec_bcd2", 32'(bcd2), 32'(model_bcd[2]));
      chk("vec_idle_grant", 32'(grant_id), 32'h0);
      tick();
      chk("vec_ack_once", 32'(ack), 32'h0);
      chk("vec_busy_gap", 32'(busy), 32'h0);
    end

    // Simultaneous requests served 0,1,2 spaced 17 cycles.
    do_reset();
    bin0 = 13'd7; bin1 = 13'd8191; bin2 = 13'd500;
    pulse(3'b111);
    wait_ack("sim0", 17, 3'b001);
    chk("sim_bcd0", 32'(bcd0), 32'h0007);
    wait_ack("sim1", 17, 3'b010);
    chk("sim_bcd1", 32'(bcd1), 32'h8191);
    wait_ack("sim2", 17, 3'b100);
    chk("sim_bcd2", 32'(bcd2), 32'h0500);

    // Fairness: requester 0 hammers, requester 2 pulses once.
    do_reset();
    bin0 = 13'd3; bin2 = 13'd7;
    ack_log.delete();
    for (int c = 0; c < 55; c++) begin
      req = (c == 0) ? 3'b101 : 3'b001;
      tick();
      if (ack != 3'b000) ack_log.push_back(ack);
    end
    req = 3'b000;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack != 3'b000) ack_log.push_back(ack);
    end
    chk("fair_count", 32'(ack_log.size() >= 3), 32'h1);
    chk("fair_first", 32'(ack_log[0]), 32'h1);
    chk("fair_second", 32'(ack_log[1]), 32'h4);
    chk("fair_third", 32'(ack_log[2]), 32'h1);
    chk("fair_bcd2", 32'(bcd2), 32'h0007);

    // Re-request while in flight.
    do_reset();
    bin0 = 13'd10;
    pulse(3'b001);
    for (int c = 0; c < 5; c++) tick();
    bin0 = 13'd11;
    pulse(3'b001);
    wait_ack("rereq1", 11, 3'b001);
    chk("rereq1_bcd0", 32'(bcd0), 32'h0010);
    wait_ack("rereq2", 17, 3'b001);
    chk("rereq2_bcd0", 32'(bcd0), 32'h0011);

    // Reset at cnt=8 aborts the conversion.
    bin1 = 13'd77;
    pulse(3'b010);
    for (int c = 0; c < 9; c++) tick();
    chk("abort_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_bcd0", 32'(bcd0), 32'h0);
    chk("abort_bcd1", 32'(bcd1), 32'h0);
    chk("abort_conv_bin", 32'(conv_bin), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_grant", 32'(grant_id), 32'h0);
    nack = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack != 3'b000) nack++;
    end
    chk("abort_no_ack", 32'(nack), 32'h0);
    chk("abort_bcd1_hold", 32'(bcd1), 32'h0);

    // Same value converted twice.
    bin2 = 13'd999;
    pulse(3'b100);
    wait_ack("same1", 17, 3'b100);
    chk("same1_bcd2", 32'(bcd2), 32'h0999);
    pulse(3'b100);
    wait_ack("same2", 17, 3'b100);
    chk("same2_bcd2", 32'(bcd2), 32'h0999);
    chk("same_conv_bin", 32'(conv_bin), 32'd999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
